// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the Y86-64 fetch stage and the PC sequencer.
// The master drives instruction, stall and redirect information; the slave returns the fetch address and status.
interface pc_sequencer_if #(
    parameter int DATA_WID = 64
);
    logic [3:0]          icode;
    logic [DATA_WID-1:0] valC;
    logic                instr_valid;
    logic                stall;
    logic                redirect;
    logic [DATA_WID-1:0] redirect_pc;
    logic                ret_valid;
    logic [DATA_WID-1:0] ret_pc;
    logic [DATA_WID-1:0] pc;
    logic [DATA_WID-1:0] valP;
    logic                pc_valid;
    logic                halted;
    logic                bad_instr;

    modport master (
        output icode, valC, instr_valid, stall, redirect, redirect_pc, ret_valid, ret_pc,
        input  pc, valP, pc_valid, halted, bad_instr
    );

    modport slave (
        input  icode, valC, instr_valid, stall, redirect, redirect_pc, ret_valid, ret_pc,
        output pc, valP, pc_valid, halted, bad_instr
    );
endinterface

// File: rtl/pc_sequencer.sv
// Y86-64 fetch-address sequencer: registered PC, sequential successor (valP),
// taken prediction for JXX/CALL, a RET hold-off, and HALT/ERROR status.
module pc_sequencer #(
    parameter int                  DATA_WID = 64,
    parameter logic [DATA_WID-1:0] RESET_PC = '0,
    parameter bit                  IADDQ_EN = 1'b1
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] I_IADDQ = 4'hC;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_RET_WAIT,
        ST_HALT,
        ST_ERROR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_WID-1:0] pc_reg;
    logic [DATA_WID-1:0] pc_next;
    logic [3:0]          len;
    logic                icode_ok;

    // Instruction length decode; undefined icodes contribute zero and are flagged.
    always_comb begin
        len      = 4'd0;
        icode_ok = 1'b1;
        case (bus.icode)
            I_HALT:                        len = 4'd0;
            I_NOP, I_RET:                  len = 4'd1;
            I_RRMOV, I_OP, I_PUSH, I_POP:  len = 4'd2;
            I_JXX, I_CALL:                 len = 4'd9;
            I_IRMOV, I_RMMOV, I_MRMOV:     len = 4'd10;
            I_IADDQ: begin
                if (IADDQ_EN) begin
                    len = 4'd10;
                end else begin
                    icode_ok = 1'b0;
                end
            end
            default:                       icode_ok = 1'b0;
        endcase
    end

    assign bus.valP = pc_reg + DATA_WID'(len);

    // Redirect beats a pending return, which beats stall, which beats normal advance.
    always_comb begin
        pc_next    = pc_reg;
        state_next = state;
        if (bus.redirect) begin
            pc_next    = bus.redirect_pc;
            state_next = ST_RUN;
        end else if (state == ST_RET_WAIT && bus.ret_valid) begin
            pc_next    = bus.ret_pc;
            state_next = ST_RUN;
        end else if (bus.stall) begin
            pc_next    = pc_reg;
            state_next = state;
        end else if (state == ST_RUN && bus.instr_valid) begin
            if (!icode_ok) begin
                state_next = ST_ERROR;
            end else begin
                case (bus.icode)
                    I_JXX, I_CALL: pc_next    = bus.valC;
                    I_RET:         state_next = ST_RET_WAIT;
                    I_HALT:        state_next = ST_HALT;
                    default:       pc_next    = bus.valP;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= RESET_PC;
            state  <= ST_RUN;
        end else begin
            pc_reg <= pc_next;
            state  <= state_next;
        end
    end

    assign bus.pc        = pc_reg;
    assign bus.pc_valid  = (state == ST_RUN);
    assign bus.halted    = (state == ST_HALT);
    assign bus.bad_instr = (state == ST_ERROR);
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: two instances (IADDQ enabled / disabled) share one
// stimulus stream and are checked against a simple fetch model.
module tb_pc_sequencer;
    localparam int          W      = 64;
    localparam logic [W-1:0] RST_PC = 64'h100;
    // Instruction byte lengths indexed by icode; -1 marks an undefined encoding.
    localparam int LEN_TAB [16] = '{0, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 10, -1, -1, -1};

    typedef struct packed {
        logic [1:0][W-1:0] valp;
        logic [1:0][W-1:0] pc;
        logic [1:0]        pv;
        logic [1:0]        hl;
        logic [1:0]        bd;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   icode;
    logic [W-1:0] valC, redirect_pc, ret_pc;
    logic         instr_valid, stall, redirect, ret_valid;

    int errors = 0;
    int checks = 0;
    rec_t sb_q [$];

    logic [W-1:0] m_pc [2];
    bit m_wait [2];
    bit m_halt [2];
    bit m_err  [2];

    always #5 clk = ~clk;

    pc_sequencer_if #(.DATA_WID(W)) bus_a ();
    pc_sequencer_if #(.DATA_WID(W)) bus_b ();

    assign bus_a.icode = icode;        assign bus_b.icode = icode;
    assign bus_a.valC = valC;          assign bus_b.valC = valC;
    assign bus_a.instr_valid = instr_valid; assign bus_b.instr_valid = instr_valid;
    assign bus_a.stall = stall;        assign bus_b.stall = stall;
    assign bus_a.redirect = redirect;  assign bus_b.redirect = redirect;
    assign bus_a.redirect_pc = redirect_pc; assign bus_b.redirect_pc = redirect_pc;
    assign bus_a.ret_valid = ret_valid; assign bus_b.ret_valid = ret_valid;
    assign bus_a.ret_pc = ret_pc;      assign bus_b.ret_pc = ret_pc;

    pc_sequencer #(.DATA_WID(W), .RESET_PC(RST_PC), .IADDQ_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    pc_sequencer #(.DATA_WID(W), .RESET_PC(RST_PC), .IADDQ_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    logic [W-1:0] got_pc [2];
    logic [W-1:0] got_valp [2];
    logic         got_pv [2];
    logic         got_hl [2];
    logic         got_bd [2];
    assign got_pc[0] = bus_a.pc;        assign got_pc[1] = bus_b.pc;
    assign got_valp[0] = bus_a.valP;    assign got_valp[1] = bus_b.valP;
    assign got_pv[0] = bus_a.pc_valid;  assign got_pv[1] = bus_b.pc_valid;
    assign got_hl[0] = bus_a.halted;    assign got_hl[1] = bus_b.halted;
    assign got_bd[0] = bus_a.bad_instr; assign got_bd[1] = bus_b.bad_instr;

    task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = RST_PC; m_wait[k] = 0; m_halt[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s.dut%0d.pc", tag, k), got_pc[k], RST_PC);
            checkOutput($sformatf("%s.dut%0d.pc_valid", tag, k), W'(got_pv[k]), W'(1));
            checkOutput($sformatf("%s.dut%0d.halted", tag, k), W'(got_hl[k]), W'(0));
            checkOutput($sformatf("%s.dut%0d.bad_instr", tag, k), W'(got_bd[k]), W'(0));
        end
    endtask

    // Drives one cycle of inputs at the falling edge and queues what each instance should show.
    task automatic applyStimulus(input logic [3:0] ic, input logic [W-1:0] c, input logic iv,
                                 input logic st, input logic rd, input logic [W-1:0] rpc,
                                 input logic rv, input logic [W-1:0] rtp);
        rec_t r;
        @(negedge clk);
        icode = ic; valC = c; instr_valid = iv; stall = st;
        redirect = rd; redirect_pc = rpc; ret_valid = rv; ret_pc = rtp;
        for (int k = 0; k < 2; k++) begin
            int len;
            bit running;
            len = LEN_TAB[ic];
            if (ic == 4'hC && k == 1) len = -1;
            r.valp[k] = m_pc[k] + ((len < 0) ? {W{1'b0}} : W'(len));
            running = !m_wait[k] && !m_halt[k] && !m_err[k];
            if (rd) begin
                m_pc[k] = rpc; m_wait[k] = 0; m_halt[k] = 0; m_err[k] = 0;
            end else if (m_wait[k] && rv) begin
                m_pc[k] = rtp; m_wait[k] = 0;
            end else if (!st && running && iv) begin
                if (len < 0) m_err[k] = 1;
                else if (ic == 4'h7 || ic == 4'h8) m_pc[k] = c;
                else if (ic == 4'h9) m_wait[k] = 1;
                else if (ic == 4'h0) m_halt[k] = 1;
                else m_pc[k] = r.valp[k];
            end
            r.pc[k] = m_pc[k];
            r.pv[k] = !m_wait[k] && !m_halt[k] && !m_err[k];
            r.hl[k] = m_halt[k];
            r.bd[k] = m_err[k];
        end
        sb_q.push_back(r);
    endtask

    task automatic issue(input logic [3:0] ic, input logic [W-1:0] c);
        applyStimulus(ic, c, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic idle();
        applyStimulus(4'h1, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic jump_to(input logic [W-1:0] a);
        applyStimulus(4'h1, '0, 1'b1, 1'b0, 1'b1, a, 1'b0, '0);
    endtask

    // Monitor: valP is sampled before the edge, registered outputs just after it.
    initial begin
        rec_t r;
        logic [W-1:0] vp [2];
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() != 0) begin
                vp[0] = got_valp[0];
                vp[1] = got_valp[1];
                @(posedge clk);
                #1;
                r = sb_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    checkOutput($sformatf("dut%0d.valP", k), vp[k], r.valp[k]);
                    checkOutput($sformatf("dut%0d.pc", k), got_pc[k], r.pc[k]);
                    checkOutput($sformatf("dut%0d.pc_valid", k), W'(got_pv[k]), W'(r.pv[k]));
                    checkOutput($sformatf("dut%0d.halted", k), W'(got_hl[k]), W'(r.hl[k]));
                    checkOutput($sformatf("dut%0d.bad_instr", k), W'(got_bd[k]), W'(r.bd[k]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; icode = 4'h1; valC = '0; instr_valid = 0; stall = 0;
        redirect = 0; redirect_pc = '0; ret_valid = 0; ret_pc = '0;
        model_reset();
        #3;
        checkResetState("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // NOP stream from the reset address
        repeat (3) issue(4'h1, '0);

        // Mixed lengths, predicted-taken jump, CALL successor and an undefined icode
        jump_to('0);
        issue(4'h3, '0);
        issue(4'h6, '0);
        issue(4'h7, 64'h40);
        jump_to('0);
        issue(4'h8, 64'h200);
        issue(4'hD, '0);
        issue(4'h1, '0);

        // RET bubble, then a return address that wins over stall
        jump_to(64'h20);
        issue(4'h9, '0);
        repeat (3) issue(4'h1, '0);
        applyStimulus(4'h1, '0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 64'h55);

        // HALT is absorbing until redirected
        jump_to(64'h30);
        issue(4'h0, '0);
        repeat (5) issue(4'h1, '0);
        jump_to(64'h80);

        // Simultaneous redirect, stall and return; stall alone; ret_valid outside RET_WAIT
        issue(4'h9, '0);
        applyStimulus(4'h1, '0, 1'b1, 1'b1, 1'b1, 64'h300, 1'b1, 64'h400);
        applyStimulus(4'h1, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        applyStimulus(4'h1, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 64'h999);

        // IADDQ legal on one instance, an error on the other
        issue(4'hC, '0);
        issue(4'h1, '0);

        // Wrap-around of the successor address
        jump_to(64'hFFFF_FFFF_FFFF_FFFE);
        issue(4'hA, '0);
        jump_to(64'hFFFF_FFFF_FFFF_FFFF);
        issue(4'h1, '0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), {$urandom, $urandom},
                          ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) == 0), {$urandom, $urandom},
                          ($urandom_range(0, 3) == 0), {$urandom, $urandom});
        end

        // Asynchronous reset in the middle of a RET wait
        jump_to(64'h500);
        issue(4'h9, '0);
        idle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checkResetState("async_reset");
        @(negedge clk);
        rst = 1'b0;
        issue(4'h1, '0);
        issue(4'h2, '0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
